pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit.sv | 80 ++++++++
 tb/tb_pc_fetch_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: two-state instruction fetch with branch/jump redirect; define PC_MISALIGN_CHECK_EN to reject misaligned redirect targets
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        b_out,
  input  logic [31:0] branch_target,
  input  logic        jump_en,
  input  logic [31:0] jump_target,
  input  logic        stall,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        misalign
);
  typedef enum logic {FETCH, VALID} state_e;
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, ipc_q, ipc_d;
  logic [31:0] raw_target, target;
  logic        redirect, take;
  assign redirect   = jump_en | b_out;
  assign raw_target = jump_en ? jump_target : branch_target;
`ifdef PC_MISALIGN_CHECK_EN
  logic misalign_q;
  assign target   = raw_target;
  assign take     = redirect & (raw_target[1:0] == 2'b00);
  assign misalign = misalign_q;
  // a rejected redirect pulses misalign for exactly the following cycle
  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= redirect & ~take;
  end
`else
  assign target   = raw_target & 32'hFFFF_FFFC;
  assign take     = redirect;
  assign misalign = 1'b0;
`endif
  assign imem_req    = state_q == FETCH;
  assign imem_addr   = pc_q;
  assign instr_valid = state_q == VALID;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  // redirect beats everything (including a same-cycle ack and stall), then capture, then release
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    if (take) begin
      state_d = FETCH;
      pc_d    = target;
    end else if (state_q == FETCH && imem_ack) begin
      state_d = VALID;
      instr_d = imem_rdata;
      ipc_d   = pc_q;
      pc_d    = pc_q + 32'd4;
    end else if (state_q == VALID && !stall) begin
      state_d = FETCH;
    end
  end
  // state registers; reset loads the boot PC and a NOP
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0000_0013;
      ipc_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: vector table, corner sequences and randomized run against a behavioural model
module tb_pc_fetch_unit;
  localparam logic [31:0] RPC = 32'h0000_0100;
  logic        clk = 1'b0;
  logic        rst, b_out, jump_en, stall, imem_ack;
  logic [31:0] branch_target, jump_target, imem_rdata;
  logic        imem_req, instr_valid, misalign;
  logic [31:0] imem_addr, instr, instr_pc;
  int vectors = 0;
  int miscompares = 0;
  logic        m_pres, m_mis;
  logic [31:0] m_pc, m_instr, m_ipc;

  pc_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .b_out(b_out), .branch_target(branch_target),
    .jump_en(jump_en), .jump_target(jump_target), .stall(stall),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .imem_req(imem_req),
    .imem_addr(imem_addr), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // behavioural model: one instruction is either being requested or being presented
  task automatic model_step();
    logic [31:0] tgt;
    logic        want, ok;
    if (rst) begin
      m_pc = RPC; m_pres = 0; m_instr = 32'h13; m_ipc = RPC; m_mis = 0;
    end else begin
      want = jump_en || b_out;
      tgt  = jump_en ? jump_target : branch_target;
`ifdef PC_MISALIGN_CHECK_EN
      ok    = want && (tgt % 4 == 0);
      m_mis = want && (tgt % 4 != 0);
`else
      ok    = want;
      tgt   = tgt - (tgt % 4);
      m_mis = 0;
`endif
      if (ok) begin
        m_pc = tgt; m_pres = 0;
      end else if (!m_pres && imem_ack) begin
        m_instr = imem_rdata; m_ipc = m_pc; m_pc = m_pc + 4; m_pres = 1;
      end else if (m_pres && !stall) begin
        m_pres = 0;
      end
    end
  endtask

  task automatic model_check();
    chk("model_req", {31'd0, imem_req}, {31'd0, !m_pres});
    chk("model_valid", {31'd0, instr_valid}, {31'd0, m_pres});
    chk("model_instr", instr, m_instr);
    chk("model_instr_pc", instr_pc, m_ipc);
    chk("model_misalign", {31'd0, misalign}, {31'd0, m_mis});
    if (!m_pres) chk("model_addr", imem_addr, m_pc);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    model_check();
  endtask

  task automatic idle();
    rst = 0; b_out = 0; jump_en = 0; stall = 0; imem_ack = 0;
  endtask

  typedef struct {
    logic rst, b_out; logic [31:0] bt; logic jen; logic [31:0] jt;
    logic stall, ack; logic [31:0] rdata;
    logic req; logic [31:0] addr; logic valid; logic [31:0] ins, ipc;
  } vec_t;
  vec_t tbl[16];

  initial begin
    idle(); rst = 1; branch_target = 0; jump_target = 0; imem_rdata = 0;
    //          rst b  bt        jen jt        st ack rdata     req addr      v  instr     ipc
    tbl[0]  = '{1, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   1, 32'h100, 0, 32'h13, 32'h100};
    tbl[1]  = '{0, 0, 32'h0,   0, 32'h0,   0, 1, 32'hA,   0, 32'h0,   1, 32'hA,  32'h100};
    tbl[2]  = '{0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   1, 32'h104, 0, 32'hA,  32'h100};
    tbl[3]  = '{0, 0, 32'h0,   0, 32'h0,   0, 1, 32'hB,   0, 32'h0,   1, 32'hB,  32'h104};
    tbl[4]  = '{0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   1, 32'h108, 0, 32'hB,  32'h104};
    tbl[5]  = '{0, 0, 32'h0,   0, 32'h0,   0, 1, 32'hC,   0, 32'h0,   1, 32'hC,  32'h108};
    tbl[6]  = '{0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   0, 32'h0,   1, 32'hC,  32'h108};
    tbl[7]  = '{0, 0, 32'h0,   0, 32'h0,   1, 1, 32'hF,   0, 32'h0,   1, 32'hC,  32'h108};
    tbl[8]  = '{0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   0, 32'h0,   1, 32'hC,  32'h108};
    tbl[9]  = '{0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   1, 32'h10C, 0, 32'hC,  32'h108};
    tbl[10] = '{0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   1, 32'h10C, 0, 32'hC,  32'h108};
    tbl[11] = '{0, 1, 32'h200, 0, 32'h0,   0, 1, 32'hD,   1, 32'h200, 0, 32'hC,  32'h108};
    tbl[12] = '{0, 1, 32'h400, 1, 32'h300, 0, 0, 32'h0,   1, 32'h300, 0, 32'hC,  32'h108};
    tbl[13] = '{0, 0, 32'h0,   0, 32'h0,   0, 1, 32'hE,   0, 32'h0,   1, 32'hE,  32'h300};
    tbl[14] = '{0, 1, 32'h500, 0, 32'h0,   1, 0, 32'h0,   1, 32'h500, 0, 32'hE,  32'h300};
    tbl[15] = '{1, 0, 32'h0,   1, 32'h700, 1, 1, 32'h99,  1, 32'h100, 0, 32'h13, 32'h100};
    for (int i = 0; i < 16; i++) begin
      rst = tbl[i].rst; b_out = tbl[i].b_out; branch_target = tbl[i].bt;
      jump_en = tbl[i].jen; jump_target = tbl[i].jt; stall = tbl[i].stall;
      imem_ack = tbl[i].ack; imem_rdata = tbl[i].rdata;
      tick();
      chk($sformatf("tbl%0d_req", i), {31'd0, imem_req}, {31'd0, tbl[i].req});
      chk($sformatf("tbl%0d_valid", i), {31'd0, instr_valid}, {31'd0, tbl[i].valid});
      chk($sformatf("tbl%0d_instr", i), instr, tbl[i].ins);
      chk($sformatf("tbl%0d_instr_pc", i), instr_pc, tbl[i].ipc);
      chk($sformatf("tbl%0d_misalign", i), {31'd0, misalign}, 32'd0);
      if (tbl[i].req) chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
    end
    idle(); jump_en = 1; jump_target = 32'hFFFF_FFFC;
    tick();
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    idle(); imem_ack = 1; imem_rdata = 32'h77;
    tick();
    chk("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
    idle();
    tick();
    chk("wrap_next_addr", imem_addr, 32'h0);
    chk("wrap_next_req", {31'd0, imem_req}, 32'd1);
    idle(); jump_en = 1; jump_target = 32'h202;
    tick();
`ifdef PC_MISALIGN_CHECK_EN
    chk("mis_pulse", {31'd0, misalign}, 32'd1);
    chk("mis_addr", imem_addr, 32'h0);
`else
    chk("mis_pulse", {31'd0, misalign}, 32'd0);
    chk("mis_addr", imem_addr, 32'h200);
`endif
    idle();
    tick();
    chk("mis_clear", {31'd0, misalign}, 32'd0);
    for (int n = 0; n < 3000; n++) begin
      rst           = ($urandom_range(0, 99) < 2);
      jump_en       = ($urandom_range(0, 99) < 6);
      b_out         = ($urandom_range(0, 99) < 8);
      jump_target   = $urandom();
      branch_target = ($urandom_range(0, 1) != 0) ? {$urandom_range(0, 1023), 2'b00} : $urandom();
      stall         = ($urandom_range(0, 99) < 30);
      imem_ack      = ($urandom_range(0, 99) < 60);
      imem_rdata    = $urandom();
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
